frame_read: RTL and testbench
=============================

Name: frame_read

Overview:
- Reads a stored convolution output frame (OUT_WIDTH x OUT_HEIGHT words of 48-bit {R16,G16,B16}) from the output frame memory through its synchronous read port.
- Streams the frame out as 24-bit RGB888 pixels under a valid/ready handshake.
- Sits after the frame-memory writer. It starts once the writer reports completion, and feeds the display/UART/readback path.
- Each 16-bit channel is clamped to 8 bits, and the stream carries start-of-frame, end-of-line and end-of-frame markers.

Parameters:
- OUT_WIDTH, 30, pixels per line.
- OUT_HEIGHT, 30, lines per frame.
- ADDR_W, 10, read address width. Must satisfy 2^ADDR_W >= OUT_WIDTH*OUT_HEIGHT.

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame readout. Ignored unless idle.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  48  memory data {R,G,B}, each 16-bit signed. Valid exactly 1 cycle after rd_en.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  24  {R8,G8,B8}.
- pix_sof  out  1  qualifies the first pixel of the frame.
- pix_eol  out  1  qualifies the last pixel of each line.
- pix_eof  out  1  qualifies the last pixel of the frame.
- busy  out  1  high from start acceptance until the final handshake.
- done  out  1  one-cycle pulse the cycle after the final handshake.

Behaviour:
- Reset (async, rstb=1):
  - State IDLE; all counters 0.
  - rd_en=0, rd_addr=0, pix_valid=0, pix_data=0, pix_sof/eol/eof=0, busy=0, done=0.
  - Any in-flight read is discarded.
- Handshake:
  - A transfer occurs on any cycle with pix_valid & pix_ready.
  - Once pix_valid is high, pix_data and the markers hold stable until transfer.
  - pix_valid never depends combinationally on pix_ready.
- Buffering:
  - Internal 2-entry output FIFO plus a 1-bit in-flight flag for the read issued last cycle.
  - A read is issued when occupancy + in_flight - pop < 2 and read_addr < OUT_WIDTH*OUT_HEIGHT.
  - The FIFO must never overflow.
  - With pix_ready held high, throughput is 1 pixel/cycle after the initial latency.
- Latency: start to first pix_valid = 2 cycles. Issue the read on cycle +1, capture into the FIFO, valid on cycle +2.
- State machine:
  - IDLE -> READ on start.
  - READ -> DRAIN when the last address is issued.
  - DRAIN -> IDLE when the final pixel transfers. done pulses the next cycle.
  - start during READ/DRAIN is ignored.
- Addressing: rd_addr increments by 1 per issued read, from 0 to OUT_WIDTH*OUT_HEIGHT-1, with no wrap.
- Markers: col/row counters advance on each transfer. Asserted with their pixel:
  - sof at (0,0).
  - eol at col=OUT_WIDTH-1.
  - eof at the last pixel; eof implies eol.
- Channel conversion (registered at FIFO entry):
  - Signed 16-bit value v maps to 0 if v<0, 255 if v>255, else v[7:0].
- Simultaneous events:
  - start in the same cycle as done: accepted. The new frame restarts at address 0.
  - pix_ready low indefinitely: reads stall once the FIFO is full. No data is lost.
- Reset mid-frame: immediate return to IDLE. The next start reads from address 0.

Optional Feature:
- Macro GRAY_OUT_EN.
- Defined: after clamping, Y = (77*R8 + 150*G8 + 29*B8) >> 8, using a 16-bit intermediate. pix_data = {Y,Y,Y}. Conversion adds one register stage, so start to first pix_valid = 3 cycles. The FIFO threshold accounts for 2 in-flight entries, so 1 pixel/cycle is still sustained.
- Undefined: pix_data is the clamped RGB888, and latency is 2 cycles.

Test Plan:
- Memory preloaded with addr a = {a,a,a}; pulse start; pix_ready=1 -> 900 transfers in consecutive cycles. The pixel at address a has pix_data = {min(a,255)} x3. sof on pixel 0; eol on pixels 29, 59, ..., 899; eof on pixel 899 only. done pulses once, and busy drops on the same cycle.
- Clamp: word {16'hFFFF, 16'h0100, 16'h0080} -> pix_data 24'h00FF80.
- Backpressure: pix_ready toggles 1,0,0,1 repeatedly -> data stable while stalled. The sequence matches the no-stall run exactly, and rd_en stops issuing once the FIFO holds 2 entries.
- start pulsed during READ at pixel 100 -> ignored. Exactly 900 pixels are output and one done occurs.
- rstb asserted at pixel 450 with pix_valid high -> pix_valid=0 and busy=0 immediately. A subsequent start restarts at address 0 with sof on the first pixel.
- With GRAY_OUT_EN, word {255,0,0} -> pix_data 24'h4C4C4C. First pix_valid appears 3 cycles after start.

Source files
------------

// File: rtl/frame_read.sv
// frame_read: streams a stored 48-bit {R16,G16,B16} frame as clamped RGB888 pixels with sof/eol/eof markers.
// Optional GRAY_OUT_EN: one extra stage converts each pixel to {Y,Y,Y}; start-to-valid latency becomes 3 cycles.
module frame_read #(
    parameter int OUT_WIDTH  = 30,
    parameter int OUT_HEIGHT = 30,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [47:0]       rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
);
    localparam int NPIX = OUT_WIDTH * OUT_HEIGHT;
`ifdef GRAY_OUT_EN
    // Three words can be outstanding (memory, clamp stage, FIFO); depth 3 keeps one pixel per cycle.
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(OUT_WIDTH + 1);
    localparam int RW = $clog2(OUT_HEIGHT + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_busy;
    logic              r_done;
    logic              r_inflight;
    logic [23:0]       r_fifo [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [1:0]        r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_last_pix;
    logic [1:0]        w_infl;
    logic [2:0]        w_level;
    logic [2:0]        w_limit;
    logic [23:0]       w_clamped;
    logic [23:0]       w_push_dat;

    function automatic logic [7:0] clamp8(input logic [15:0] v);
        if (v[15])
            return 8'd0;
        else if (v[14:8] != 7'd0)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    assign w_clamped = {clamp8(rd_data[47:32]), clamp8(rd_data[31:16]), clamp8(rd_data[15:0])};

`ifdef GRAY_OUT_EN
    logic        r_s1_vld;
    logic [23:0] r_s1_dat;
    logic [15:0] w_ysum;
    logic [7:0]  w_y;

    assign w_ysum = 16'd77  * {8'd0, r_s1_dat[23:16]}
                  + 16'd150 * {8'd0, r_s1_dat[15:8]}
                  + 16'd29  * {8'd0, r_s1_dat[7:0]};
    assign w_y    = 8'(w_ysum >> 8);

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= r_inflight;
            if (r_inflight)
                r_s1_dat <= w_clamped;
        end
    end

    assign w_push     = r_s1_vld;
    assign w_push_dat = {w_y, w_y, w_y};
    assign w_infl     = {1'b0, r_inflight} + {1'b0, r_s1_vld};
`else
    assign w_push     = r_inflight;
    assign w_push_dat = w_clamped;
    assign w_infl     = {1'b0, r_inflight};
`endif

    assign pix_valid  = (r_count != 2'd0);
    assign pix_data   = r_fifo[r_rptr];
    assign w_pop      = pix_valid & pix_ready;
    assign w_last_pix = (r_col == CW'(OUT_WIDTH - 1)) && (r_row == RW'(OUT_HEIGHT - 1));

    // Issue only if every word already on its way, plus this one, still fits after this cycle's pop.
    assign w_level = 3'(r_count) + 3'(w_infl);
    assign w_limit = 3'(DEPTH) + 3'(w_pop);
    assign w_issue = (r_state == S_READ) && (w_level < w_limit);

    assign rd_en   = w_issue;
    assign rd_addr = r_addr;
    assign pix_sof = pix_valid && (r_col == '0) && (r_row == '0);
    assign pix_eol = pix_valid && (r_col == CW'(OUT_WIDTH - 1));
    assign pix_eof = pix_valid && w_last_pix;
    assign busy    = r_busy;
    assign done    = r_done;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            r_inflight <= 1'b0;
        else
            r_inflight <= w_issue;
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int i = 0; i < DEPTH; i++)
                r_fifo[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_push_dat;
                r_wptr         <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pop) begin
            if (r_col == CW'(OUT_WIDTH - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(OUT_HEIGHT - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    // Address holds at the last word once issued; no wrap.
                    if (w_issue) begin
                        if (r_addr == ADDR_W'(NPIX - 1))
                            r_state <= S_DRAIN;
                        else
                            r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last_pix) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_read.sv
// Bench for frame_read: synchronous memory model, scoreboard fed at start, monitor checks every transfer.
module tb_frame_read;
    localparam int W  = 30;
    localparam int H  = 30;
    localparam int N  = W * H;
    localparam int AW = 10;
`ifdef GRAY_OUT_EN
    localparam int LAT   = 3;
    localparam int DEPTH = 3;
`else
    localparam int LAT   = 2;
    localparam int DEPTH = 2;
`endif

    logic          clk, rstb, start, rd_en, pix_valid, pix_ready;
    logic          pix_sof, pix_eol, pix_eof, busy, done;
    logic [AW-1:0] rd_addr;
    logic [47:0]   rd_data;
    logic [23:0]   pix_data;

    frame_read #(.OUT_WIDTH(W), .OUT_HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rstb(rstb), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        logic [23:0] dat;
    } px_t;

    logic [47:0] mem [0:1023];
    px_t         exp_q[$];
    int          total = 0, bad = 0;
    int          rmode = 0;
    int          issued = 0, xfers = 0, frame_xfers = 0, done_cnt = 0;
    int          cyc = 0, sof_cyc = 0, span = -1;
    logic [23:0] first_px, second_px;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_i(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    function automatic logic [23:0] model_pix(input logic [47:0] w);
        int r, g, b;
        r = clamp_i(w[47:32]);
        g = clamp_i(w[31:16]);
        b = clamp_i(w[15:0]);
`ifdef GRAY_OUT_EN
        begin
            int y;
            y = (77 * r + 150 * g + 29 * b) / 256;
            return {8'(y), 8'(y), 8'(y)};
        end
`else
        return {8'(r), 8'(g), 8'(b)};
`endif
    endfunction

    function automatic logic [15:0] rand_ch();
        case ($urandom_range(0, 3))
            0:       return 16'(32'h8000 | $urandom);
            1:       return 16'(256 + $urandom_range(0, 32000));
            2:       return 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    // Downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random.
    initial begin
        int ph = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    pix_ready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                2:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = 1'b1;
            endcase
        end
    end

    // Monitor: transfers, stalls, read-issue discipline, done.
    initial begin
        px_t cur, held, e;
        logic held_vld = 1'b0;
        logic pop;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstb) begin
                held_vld = 1'b0;
                issued = 0;
                xfers = 0;
                frame_xfers = 0;
            end else begin
                cur = {pix_sof, pix_eol, pix_eof, pix_data};
                pop = pix_valid && pix_ready;
                if (held_vld) begin
                    chk("valid_held", pix_valid, 1);
                    chk("stall_stable", cur, held);
                end
                held_vld = pix_valid && !pix_ready;
                held = cur;
                if (rd_en) begin
                    chk("rd_addr", rd_addr, issued % N);
                    chk("outstanding_le_depth", (issued + 1 - xfers - int'(pop)) <= DEPTH, 1);
                    issued++;
                end
                if (pop) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL pixel_unexpected: got %0h required no transfer", cur);
                    end else begin
                        e = exp_q.pop_front();
                        total--;
                        chk("pixel", cur, e);
                    end
                    if (frame_xfers == 0) first_px = pix_data;
                    if (frame_xfers == 1) second_px = pix_data;
                    if (pix_sof) sof_cyc = cyc;
                    if (pix_eof) span = cyc - sof_cyc;
                    xfers++;
                    frame_xfers = pix_eof ? 0 : frame_xfers + 1;
                end
                if (done) begin
                    done_cnt++;
                    chk("busy_low_at_done", busy, 0);
                    chk("queue_empty_at_done", exp_q.size(), 0);
                end
            end
        end
    end

    task automatic start_now();
        for (int i = 0; i < N; i++)
            exp_q.push_back({i == 0, (i % W) == W - 1, i == N - 1, model_pix(mem[i])});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        start_now();
    endtask

    // Returns inside the done cycle, after the monitor has sampled it.
    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!done && n < 6000);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done required done within 6000 cycles", name);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int k);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(frame_xfers >= k && pix_valid) && n < 6000);
        if (n >= 6000) begin
            total++;
            bad++;
            $display("FAIL wait_xfers_timeout: got %0d required %0d", frame_xfers, k);
        end
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < 1024; a++) begin
            logic [15:0] v;
            v = 16'(a);
            mem[a] = {v, v, v};
        end
    endtask

    initial begin
        int d0;
        rstb = 1'b1;
        start = 1'b0;
        fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_markers", {pix_sof, pix_eol, pix_eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstb = 1'b0;

        // Ramp frame, ready always high: latency, throughput, markers.
        rmode = 0;
        start_frame();
        for (int j = 0; j <= LAT; j++) begin
            @(negedge clk);
            chk($sformatf("latency_valid_%0d", j), pix_valid, (j == LAT));
        end
        chk("busy_during_frame", busy, 1);
        wait_done("ramp");
        chk("ramp_consecutive_span", span, N - 1);
        chk("ramp_done_count", done_cnt, 1);

        // Random words with clamp corner cases, random backpressure.
        for (int a = 0; a < 1024; a++) mem[a] = {rand_ch(), rand_ch(), rand_ch()};
        mem[0] = {16'hFFFF, 16'h0100, 16'h0080};
        mem[1] = {16'd255, 16'd0, 16'd0};
        rmode = 2;
        start_frame();
        wait_done("clamp");
`ifdef GRAY_OUT_EN
        chk("clamp_word0", first_px, 24'hA3A3A3);
        chk("gray_word1", second_px, 24'h4C4C4C);
`else
        chk("clamp_word0", first_px, 24'h00FF80);
        chk("clamp_word1", second_px, 24'hFF0000);
`endif

        // 1,0,0,1 backpressure on the ramp frame.
        fill_ramp();
        rmode = 1;
        start_frame();
        wait_done("backpressure");

        // start mid-frame ignored; then start in the done cycle accepted.
        rmode = 0;
        d0 = done_cnt;
        start_frame();
        wait_xfers(100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start");
        start_now();
        wait_done("back_to_back");
        repeat (20) @(posedge clk);
        #1;
        chk("done_count_two_frames", done_cnt, d0 + 2);

        // Reset mid-frame, then a clean restart.
        start_frame();
        wait_xfers(450);
        rstb = 1'b1;
        #1;
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", rd_en, 0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rstb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, d0);
        start_frame();
        wait_done("after_reset");
        chk("after_reset_span", span, N - 1);

        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
